// File: rtl/wb_decoder.sv
// wb_decoder: single-master Wishbone address decoder / slave multiplexer.
//   Decodes the top DEC_BITS of the master address against a per-slave base
//   table. It raises the selected slave's cycle line and returns ack or err
//   to the master as a one-cycle response.
//   Zero-wait slaves are acked by the decoder itself.
//   Wait-state slaves are bounded by a TIMEOUT-cycle watchdog.
// Ports:
//   wb_clk, wb_rst                        clock, synchronous active-high reset
//   i_wb_adr/dat/sel/we/cyc               master request
//   o_wb_rdt/ack/err                      master response (registered)
//   o_wb_s_adr/dat/sel/we                 request broadcast to all slaves
//   o_wb_s_cyc                            one-hot slave cycle (BUSY only)
//   i_wb_s_rdt/ack                        packed slave responses
//   o_sel_idx                             last latched slave index (debug)
module wb_decoder #(
  parameter int                          NSLAVES    = 4,
  parameter int                          AW         = 32,
  parameter int                          DW         = 32,
  parameter int                          DEC_BITS   = 4,
  parameter logic [NSLAVES*DEC_BITS-1:0] SLAVE_BASE = {4'h8, 4'h4, 4'h0, 4'h0},
  parameter logic [NSLAVES-1:0]          ZERO_WAIT  = 4'b0001,
  parameter int                          TIMEOUT    = 15
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic [AW-1:0]         i_wb_adr,
  input  logic [DW-1:0]         i_wb_dat,
  input  logic [DW/8-1:0]       i_wb_sel,
  input  logic                  i_wb_we,
  input  logic                  i_wb_cyc,
  output logic [DW-1:0]         o_wb_rdt,
  output logic                  o_wb_ack,
  output logic                  o_wb_err,
  output logic [AW-1:0]         o_wb_s_adr,
  output logic [DW-1:0]         o_wb_s_dat,
  output logic [DW/8-1:0]       o_wb_s_sel,
  output logic                  o_wb_s_we,
  output logic [NSLAVES-1:0]    o_wb_s_cyc,
  input  logic [NSLAVES*DW-1:0] i_wb_s_rdt,
  input  logic [NSLAVES-1:0]    i_wb_s_ack,
  output logic [3:0]            o_sel_idx
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUSY  = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdt_q, rdt_d;

  // Request broadcast is purely combinational.
  assign o_wb_s_adr = i_wb_adr;
  assign o_wb_s_dat = i_wb_dat;
  assign o_wb_s_sel = i_wb_sel;
  assign o_wb_s_we  = i_wb_we;

  // Address decode. Scanning from the top down means the lowest-numbered
  // matching slave is the one that is chosen.
  logic       hit;
  logic [3:0] hit_idx;
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if (i_wb_adr[AW-1 -: DEC_BITS] == SLAVE_BASE[i*DEC_BITS +: DEC_BITS]) begin
        hit     = 1'b1;
        hit_idx = 4'(i);
      end
    end
  end

  // Mux of the latched slave's response. The compare loop keeps idx_q from
  // ever indexing past NSLAVES.
  logic          sel_ack, sel_zw;
  logic [DW-1:0] sel_rdt;
  always_comb begin
    sel_ack = 1'b0;
    sel_zw  = 1'b0;
    sel_rdt = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (idx_q == 4'(i)) begin
        sel_ack = i_wb_s_ack[i];
        sel_zw  = ZERO_WAIT[i];
        sel_rdt = i_wb_s_rdt[i*DW +: DW];
      end
    end
  end

  always_comb begin
    o_wb_s_cyc = '0;
    for (int i = 0; i < NSLAVES; i++)
      o_wb_s_cyc[i] = (state_q == S_BUSY) && (idx_q == 4'(i));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    rdt_d   = rdt_q;
    case (state_q)
      S_IDLE: begin
        if (i_wb_cyc) begin
          if (hit) begin
            idx_d   = hit_idx;
            cnt_d   = '0;
            state_d = S_BUSY;
          end else begin
            err_d   = 1'b1;
            rdt_d   = '0;
            state_d = S_RESP;
          end
        end
      end
      S_BUSY: begin
        // A master abort wins over everything else, and the ack wins over the timeout.
        if (!i_wb_cyc) begin
          state_d = S_IDLE;
        end else if (sel_zw || sel_ack) begin
          ack_d   = 1'b1;
          rdt_d   = sel_rdt;
          state_d = S_RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          rdt_d   = '0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP:  state_d = S_DRAIN;
      S_DRAIN: if (!i_wb_cyc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdt_q   <= rdt_d;
    end
  end

  assign o_wb_ack  = ack_q;
  assign o_wb_err  = err_q;
  assign o_wb_rdt  = rdt_q;
  assign o_sel_idx = idx_q;

endmodule

// File: tb/tb_wb_decoder.sv
// Self-checking bench for wb_decoder: directed and random transactions
// checked cycle by cycle against a table-driven transaction model.
module tb_wb_decoder;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, we, cyc;
  logic [AW-1:0]     adr;
  logic [DW-1:0]     dat;
  logic [DW/8-1:0]   sel;
  logic [DW-1:0]     o_rdt;
  logic              o_ack, o_err, o_swe;
  logic [AW-1:0]     o_sadr;
  logic [DW-1:0]     o_sdat;
  logic [DW/8-1:0]   o_ssel;
  logic [NS-1:0]     o_scyc;
  logic [NS*DW-1:0]  s_rdt;
  logic [NS-1:0]     s_ack;
  logic [3:0]        o_idx;

  // The default base table maps slaves 0 and 1 to the same nibble, which
  // shadows slave 1. This map makes every slave reachable and leaves 0xC unmapped.
  wb_decoder #(
    .NSLAVES(NS), .AW(AW), .DW(DW), .DEC_BITS(4),
    .SLAVE_BASE({4'h8, 4'h2, 4'h4, 4'h0}),
    .ZERO_WAIT(4'b0001), .TIMEOUT(TO)
  ) dut (
    .wb_clk(clk), .wb_rst(rst),
    .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel), .i_wb_we(we), .i_wb_cyc(cyc),
    .o_wb_rdt(o_rdt), .o_wb_ack(o_ack), .o_wb_err(o_err),
    .o_wb_s_adr(o_sadr), .o_wb_s_dat(o_sdat), .o_wb_s_sel(o_ssel), .o_wb_s_we(o_swe),
    .o_wb_s_cyc(o_scyc), .i_wb_s_rdt(s_rdt), .i_wb_s_ack(s_ack), .o_sel_idx(o_idx)
  );

  int checks = 0;
  int failures = 0;
  int base_tbl[NS] = '{0, 4, 2, 8};
  bit zw_tbl[NS]   = '{1'b1, 1'b0, 1'b0, 1'b0};
  int            last_idx;
  logic [DW-1:0] last_rdt;

  function automatic int decode(input logic [AW-1:0] a);
    for (int i = 0; i < NS; i++)
      if (base_tbl[i] == int'(a[AW-1 -: 4])) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One master transaction starting at k=0 (cyc sampled at the first edge).
  // d: BUSY cycles before the selected slave acks. abort_at / rst_at: the cycle
  // whose edge sees cyc low / rst high (0 means none). hold: cycles cyc stays high
  // after the response. frc: nonzero forces the selected slave's read data.
  // rogue_all: all non-selected slaves ack every cycle.
  task automatic txn(input logic [AW-1:0] a, input int d, input int abort_at,
                     input int rst_at, input int hold, input logic [DW-1:0] frc,
                     input bit rogue_all);
    int idx = decode(a);
    bit zw = 1'b0;
    bit is_err;
    int resp_k, stop_k, drop_k, end_k;
    logic [DW-1:0] resp_rdt = '0;
    if (idx >= 0) zw = zw_tbl[idx];
    if (idx < 0)            begin resp_k = 1;      is_err = 1'b1; end
    else if (zw)            begin resp_k = 2;      is_err = 1'b0; end
    else if (d + 1 <= TO)   begin resp_k = d + 2;  is_err = 1'b0; end
    else                    begin resp_k = TO + 1; is_err = 1'b1; end
    stop_k = (abort_at > 0) ? abort_at : rst_at;
    drop_k = (abort_at > 0) ? abort_at : ((rst_at > 0) ? rst_at + 1 : resp_k + hold);
    end_k  = (stop_k > 0) ? stop_k + 3 : resp_k + hold + 3;
    adr = a;
    for (int k = 0; k <= end_k; k++) begin
      bit alive, rst_done, e_ack, e_err;
      logic [NS-1:0] ecyc, ack_v;
      logic [DW-1:0] erdt;
      int eidx;
      @(negedge clk);
      alive    = (stop_k == 0) || (k <= stop_k);
      rst_done = (rst_at > 0) && (k > rst_at);
      ecyc  = (alive && idx >= 0 && k >= 1 && k < resp_k) ? (NS'(1) << idx) : '0;
      e_ack = alive && (k == resp_k) && !is_err;
      e_err = alive && (k == resp_k) && is_err;
      erdt  = rst_done ? '0 : ((alive && k >= resp_k) ? resp_rdt : last_rdt);
      eidx  = rst_done ? 0 : ((idx >= 0 && k >= 1) ? idx : last_idx);
      check("s_cyc", 128'(o_scyc), 128'(ecyc));
      check("ack",   128'(o_ack),  128'(e_ack));
      check("err",   128'(o_err),  128'(e_err));
      check("rdt",   128'(o_rdt),  128'(erdt));
      check("sel_idx", 128'(o_idx), 128'(eidx));
      check("passthru", 128'({o_sadr, o_sdat, o_ssel, o_swe}), 128'({adr, dat, sel, we}));
      // drive for the edge that ends cycle k
      cyc = (k < drop_k);
      rst = (rst_at > 0) && (k == rst_at);
      dat = $urandom;
      sel = 4'($urandom);
      we  = 1'($urandom);
      for (int i = 0; i < NS; i++) s_rdt[i*DW +: DW] = $urandom;
      if (idx >= 0 && frc != '0) s_rdt[idx*DW +: DW] = frc;
      ack_v = rogue_all ? '1 : NS'($urandom);
      if (idx >= 0 && !zw) ack_v[idx] = (k == 1 + d);
      s_ack = ack_v;
      if (k == resp_k - 1 && !is_err && idx >= 0) resp_rdt = s_rdt[idx*DW +: DW];
    end
    if (rst_at > 0) begin
      last_rdt = '0;
      last_idx = 0;
    end else begin
      if (stop_k == 0) last_rdt = resp_rdt;
      if (idx >= 0) last_idx = idx;
    end
  endtask

  initial begin
    rst = 1'b1; cyc = 1'b0; adr = '0; dat = '0; sel = '0; we = 1'b0;
    s_rdt = '0; s_ack = '0; last_rdt = '0; last_idx = 0;
    repeat (2) @(negedge clk);
    check("rst_ack",  128'(o_ack),  128'(0));
    check("rst_err",  128'(o_err),  128'(0));
    check("rst_rdt",  128'(o_rdt),  128'(0));
    check("rst_scyc", 128'(o_scyc), 128'(0));
    check("rst_idx",  128'(o_idx),  128'(0));
    rst = 1'b0;

    txn(32'h4000_0010, 3,    0, 0, 0, 32'hA5A5_A5A5, 1'b0); // wait-state slave 1
    txn(32'h0000_0100, 0,    0, 0, 0, '0, 1'b0);            // zero-wait slave 0
    txn(32'hC000_0000, 0,    0, 0, 0, '0, 1'b0);            // unmapped
    txn(32'h2000_0040, 1000, 0, 0, 0, '0, 1'b0);            // slave 2 never acks
    txn(32'h4000_0000, 2,    0, 0, 0, '0, 1'b1);            // other slaves ack constantly
    txn(32'h2000_0000, 14,   0, 0, 0, '0, 1'b0);            // ack in last BUSY cycle
    txn(32'h2000_0000, 15,   0, 0, 0, '0, 1'b0);            // ack one cycle too late
    txn(32'h4000_0000, 5,    3, 0, 0, '0, 1'b0);            // master abort mid-BUSY
    txn(32'h0000_0000, 0,    1, 0, 0, '0, 1'b0);            // abort on zero-wait slave
    txn(32'h8000_0004, 1,    0, 0, 4, '0, 1'b0);            // cyc held high after ack
    txn(32'h4000_0000, 5,    0, 2, 0, '0, 1'b0);            // reset mid-BUSY
    for (int n = 0; n < 24; n++)
      txn({4'($urandom), 28'($urandom)}, $urandom_range(0, 17), 0, 0,
          $urandom_range(0, 3), '0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
